// File: rtl/hms_timekeeper.sv
// Time-of-day core: hh:mm:ss as six BCD digits, advanced by the rising edge of
// a ~1 Hz tick, with a mode FSM for setting each field and blink flags for the display.
module hms_timekeeper #(
  parameter bit H24 = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [3:0] hh_t,
  output logic [3:0] hh_u,
  output logic [3:0] mm_t,
  output logic [3:0] mm_u,
  output logic [3:0] ss_t,
  output logic [3:0] ss_u,
  output logic [1:0] mode,
  output logic       sec_pulse,
  output logic [2:0] blank
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    SET_HH = 2'b01,
    SET_MM = 2'b10,
    SET_SS = 2'b11
  } mode_e;

  localparam logic [7:0] HH_RESET = H24 ? 8'h00 : 8'h12;

  mode_e      mode_q, mode_d;
  logic [7:0] hh_q, hh_d;
  logic [7:0] mm_q, mm_d;
  logic [7:0] ss_q, ss_d;
  logic       tick_d_q, tick_d_d;
  logic       sec_pulse_q, sec_pulse_d;
  logic [2:0] blank_q, blank_d;
  logic       tick_rise;

  // Each field is a packed BCD pair {tens, units}.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_sixty(input logic [7:0] v);
    return (v == 8'h59) ? 8'h00 : bcd_inc(v);
  endfunction

  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    if (H24) return (v == 8'h23) ? 8'h00 : bcd_inc(v);
    return (v == 8'h12) ? 8'h01 : bcd_inc(v);
  endfunction

  always_comb begin
    hh_d        = hh_q;
    mm_d        = mm_q;
    ss_d        = ss_q;
    mode_d      = mode_q;
    sec_pulse_d = 1'b0;
    blank_d     = 3'b000;
    tick_d_d    = tick_in;
    tick_rise   = tick_in & ~tick_d_q;

    unique case (mode_q)
      RUN: begin
        if (tick_rise) begin
          sec_pulse_d = 1'b1;
          ss_d        = inc_sixty(ss_q);
          if (ss_q == 8'h59) begin
            mm_d = inc_sixty(mm_q);
            if (mm_q == 8'h59) hh_d = inc_hour(hh_q);
          end
        end
        if (mode_btn) mode_d = SET_HH;
      end
      SET_HH: begin
        if (inc_btn) hh_d = inc_hour(hh_q);
        if (mode_btn) mode_d = SET_MM;
        blank_d = {~tick_in, 2'b00};
      end
      SET_MM: begin
        if (inc_btn) mm_d = inc_sixty(mm_q);
        if (mode_btn) mode_d = SET_SS;
        blank_d = {1'b0, ~tick_in, 1'b0};
      end
      SET_SS: begin
        if (inc_btn) ss_d = inc_sixty(ss_q);
        if (mode_btn) mode_d = RUN;
        blank_d = {2'b00, ~tick_in};
      end
      default: mode_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hh_q        <= HH_RESET;
      mm_q        <= 8'h00;
      ss_q        <= 8'h00;
      mode_q      <= RUN;
      tick_d_q    <= 1'b0;
      sec_pulse_q <= 1'b0;
      blank_q     <= 3'b000;
    end else begin
      hh_q        <= hh_d;
      mm_q        <= mm_d;
      ss_q        <= ss_d;
      mode_q      <= mode_d;
      tick_d_q    <= tick_d_d;
      sec_pulse_q <= sec_pulse_d;
      blank_q     <= blank_d;
    end
  end

  assign hh_t      = hh_q[7:4];
  assign hh_u      = hh_q[3:0];
  assign mm_t      = mm_q[7:4];
  assign mm_u      = mm_q[3:0];
  assign ss_t      = ss_q[7:4];
  assign ss_u      = ss_q[3:0];
  assign mode      = mode_q;
  assign sec_pulse = sec_pulse_q;
  assign blank     = blank_q;

endmodule

// File: tb/tb_hms_timekeeper.sv
// Bench for hms_timekeeper: a 24-hour and a 12-hour instance share one stimulus
// stream and are compared every cycle against an integer time-of-day model.
module tb_hms_timekeeper;

  logic clk = 1'b0;
  logic rst, tick_in, mode_btn, inc_btn;
  logic [3:0] hh_t [2];
  logic [3:0] hh_u [2];
  logic [3:0] mm_t [2];
  logic [3:0] mm_u [2];
  logic [3:0] ss_t [2];
  logic [3:0] ss_u [2];
  logic [1:0] mode [2];
  logic       sec_pulse [2];
  logic [2:0] blank [2];

  int n_compared = 0;
  int n_failed   = 0;
  int pulse_cnt  = 0;
  bit armed      = 1'b0;

  // Model state, index 0 = 24-hour instance, index 1 = 12-hour instance.
  int       m_hr [2];
  int       m_min [2];
  int       m_sec [2];
  int       m_mode [2];
  bit       m_pulse [2];
  logic [2:0] m_blank [2];
  bit       m_tprev [2];

  always #5 clk = ~clk;

  hms_timekeeper #(.H24(1'b1)) dut_24 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .hh_t(hh_t[0]), .hh_u(hh_u[0]), .mm_t(mm_t[0]), .mm_u(mm_u[0]),
    .ss_t(ss_t[0]), .ss_u(ss_u[0]), .mode(mode[0]), .sec_pulse(sec_pulse[0]),
    .blank(blank[0])
  );

  hms_timekeeper #(.H24(1'b0)) dut_12 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .hh_t(hh_t[1]), .hh_u(hh_u[1]), .mm_t(mm_t[1]), .mm_u(mm_u[1]),
    .ss_t(ss_t[1]), .ss_u(ss_u[1]), .mode(mode[1]), .sec_pulse(sec_pulse[1]),
    .blank(blank[1])
  );

  function automatic logic [23:0] dut_time(input int f);
    return {hh_t[f], hh_u[f], mm_t[f], mm_u[f], ss_t[f], ss_u[f]};
  endfunction

  function automatic logic [23:0] bcd_time(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int next_hour(input int f, input int h);
    return (f == 0) ? (h + 1) % 24 : (h % 12) + 1;
  endfunction

  task automatic check_output(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int f);
    bit rise;
    if (rst) begin
      m_hr[f]    = (f == 0) ? 0 : 12;
      m_min[f]   = 0;
      m_sec[f]   = 0;
      m_mode[f]  = 0;
      m_pulse[f] = 1'b0;
      m_blank[f] = 3'b000;
      m_tprev[f] = 1'b0;
      return;
    end
    rise       = tick_in && !m_tprev[f];
    m_tprev[f] = tick_in;
    m_blank[f] = (m_mode[f] == 0 || tick_in) ? 3'b000 : 3'(4 >> (m_mode[f] - 1));
    m_pulse[f] = 1'b0;
    case (m_mode[f])
      0: if (rise) begin
        m_pulse[f] = 1'b1;
        m_sec[f]++;
        if (m_sec[f] == 60) begin
          m_sec[f] = 0;
          m_min[f]++;
          if (m_min[f] == 60) begin
            m_min[f] = 0;
            m_hr[f]  = next_hour(f, m_hr[f]);
          end
        end
      end
      1: if (inc_btn) m_hr[f] = next_hour(f, m_hr[f]);
      2: if (inc_btn) m_min[f] = (m_min[f] + 1) % 60;
      default: if (inc_btn) m_sec[f] = (m_sec[f] + 1) % 60;
    endcase
    if (mode_btn) m_mode[f] = (m_mode[f] + 1) % 4;
  endtask

  // Advance the model on every edge, then compare shortly after the edge.
  always @(posedge clk) begin
    for (int f = 0; f < 2; f++) model_step(f);
    if (rst) armed = 1'b1;
    #1;
    if (armed) begin
      for (int f = 0; f < 2; f++) begin
        check_output((f == 0) ? "time24" : "time12", dut_time(f),
                     bcd_time(m_hr[f], m_min[f], m_sec[f]));
        check_output((f == 0) ? "mode24" : "mode12", 24'(mode[f]), 24'(m_mode[f]));
        check_output((f == 0) ? "pulse24" : "pulse12", 24'(sec_pulse[f]), 24'(m_pulse[f]));
        check_output((f == 0) ? "blank24" : "blank12", 24'(blank[f]), 24'(m_blank[f]));
      end
      if (sec_pulse[0] === 1'b1) pulse_cnt++;
    end
  end

  task automatic apply_stimulus(input logic t, input logic m, input logic i);
    @(negedge clk);
    tick_in  = t;
    mode_btn = m;
    inc_btn  = i;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tick_in = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press_mode();
    apply_stimulus(tick_in, 1'b1, 1'b0);
    apply_stimulus(tick_in, 1'b0, 1'b0);
  endtask

  task automatic press_inc(input int n);
    repeat (n) begin
      apply_stimulus(tick_in, 1'b0, 1'b1);
      apply_stimulus(tick_in, 1'b0, 1'b0);
    end
  endtask

  task automatic tick_once();
    repeat (10) apply_stimulus(1'b1, 1'b0, 1'b0);
    repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    press_mode(); press_inc(h);
    press_mode(); press_inc(m);
    press_mode(); press_inc(s);
    press_mode();
  endtask

  initial begin
    int p0;
    rst = 1'b1; tick_in = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    settle();
    check_output("reset_time24", dut_time(0), 24'h000000);
    check_output("reset_time12", dut_time(1), 24'h120000);
    check_output("reset_mode", 24'(mode[0]), 24'd0);
    check_output("reset_blank", 24'(blank[0]), 24'd0);
    check_output("reset_pulse", 24'(sec_pulse[0]), 24'd0);

    p0 = pulse_cnt;
    repeat (3) tick_once();
    settle();
    check_output("three_ticks24", dut_time(0), 24'h000003);
    check_output("three_ticks12", dut_time(1), 24'h120003);
    check_output("three_pulses", 24'(pulse_cnt - p0), 24'd3);

    do_reset();
    press_mode(); press_inc(25);
    settle();
    check_output("set_hh24", dut_time(0), 24'h010000);
    check_output("set_hh12", dut_time(1), 24'h010000);
    check_output("set_hh_mode", 24'(mode[0]), 24'd1);
    press_mode(); press_inc(61);
    tick_once(); tick_once();
    settle();
    check_output("set_mm24", dut_time(0), 24'h010100);
    check_output("set_mm_mode", 24'(mode[0]), 24'd2);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    settle();
    check_output("mode_and_inc", dut_time(0), 24'h010200);
    check_output("mode_and_inc_mode", 24'(mode[0]), 24'd3);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(k[0] ? 1'b0 : 1'b1, 1'b0, 1'b0);
      settle();
      check_output("blank_ss", 24'(blank[0]), k[0] ? 24'd1 : 24'd0);
    end
    press_mode();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    settle();
    check_output("blank_run", 24'(blank[0]), 24'd0);

    do_reset();
    set_time(23, 59, 59);
    settle();
    check_output("preset24", dut_time(0), 24'h235959);
    check_output("preset12", dut_time(1), 24'h115959);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    settle();
    check_output("carry24", dut_time(0), 24'h000000);
    check_output("carry12_noon", dut_time(1), 24'h120000);
    check_output("carry_pulse", 24'(sec_pulse[0]), 24'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    set_time(24, 59, 59);
    settle();
    check_output("preset12b", dut_time(1), 24'h125959);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    settle();
    check_output("carry12_wrap", dut_time(1), 24'h010000);
    check_output("carry24b", dut_time(0), 24'h010000);
    apply_stimulus(1'b0, 1'b0, 1'b0);

    do_reset();
    repeat (5) tick_once();
    settle();
    check_output("at_five", dut_time(0), 24'h000005);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    settle();
    check_output("tick_mode_time", dut_time(0), 24'h000006);
    check_output("tick_mode_mode", 24'(mode[0]), 24'd1);
    check_output("tick_mode_pulse", 24'(sec_pulse[0]), 24'd1);
    repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0);

    do_reset();
    set_time(14, 22, 37);
    press_mode();
    settle();
    check_output("pre_rst24", dut_time(0), 24'h142237);
    check_output("pre_rst12", dut_time(1), 24'h022237);
    check_output("pre_rst_mode", 24'(mode[0]), 24'd1);
    @(negedge clk);
    rst = 1'b1;
    settle();
    check_output("mid_rst24", dut_time(0), 24'h000000);
    check_output("mid_rst12", dut_time(1), 24'h120000);
    check_output("mid_rst_mode", 24'(mode[0]), 24'd0);
    @(negedge clk);
    rst = 1'b0;
    tick_once();
    settle();
    check_output("resume24", dut_time(0), 24'h000001);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) tick_in = ~tick_in;
      mode_btn = ($urandom_range(0, 9) == 0);
      inc_btn  = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    rst = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
